// File: rtl/id_stage_hz_pkg.sv
// id_stage_hz_pkg: shared definitions for the ID stage.
//   - MIPS opcode / funct encodings understood by the decoder
//   - ctrl_t: the registered control bundle (field order is the ID/EX layout)
//   - NOP / HALT encodings and the default link register index
package id_stage_hz_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam int REG_LINK_DEF = 31;

  typedef struct packed {
    logic reg_dest;
    logic alu_src;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic byte_en;
    logic half_en;
    logic word_en;
  } ctrl_t;

  localparam ctrl_t       CTRL_NOP  = '0;
  localparam logic [31:0] INST_NOP  = 32'h0000_0000;
  localparam logic [31:0] INST_HALT = {OP_HALT, 26'h0};

endpackage

// File: rtl/id_stage_hz_bank_register.sv
// bank_register: 2**NB_REG x NB_DATA register bank, two combinational read
// ports with write-through, one posedge write port. Entry 0 is hardwired 0.
//   i_clock, i_reset (async, active-high)
//   i_wr_en, i_wr_addr, i_wr_data : write port
//   i_rd_addr_a/b -> o_rd_data_a/b : read ports
module bank_register #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_wr_en,
  input  logic [NB_REG-1:0]  i_wr_addr,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic [NB_REG-1:0]  i_rd_addr_a,
  input  logic [NB_REG-1:0]  i_rd_addr_b,
  output logic [NB_DATA-1:0] o_rd_data_a,
  output logic [NB_DATA-1:0] o_rd_data_b
);
  localparam int DEPTH = 2**NB_REG;

  logic [NB_DATA-1:0] r_bank [DEPTH];
  logic               w_wr;

  assign w_wr = i_wr_en && (i_wr_addr != '0);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
    end else if (w_wr) begin
      r_bank[i_wr_addr] <= i_wr_data;
    end
  end

  // write-through: a WB in the same cycle is visible to the decoder
  assign o_rd_data_a = (i_rd_addr_a == '0) ? '0 :
                       (w_wr && i_wr_addr == i_rd_addr_a) ? i_wr_data : r_bank[i_rd_addr_a];
  assign o_rd_data_b = (i_rd_addr_b == '0) ? '0 :
                       (w_wr && i_wr_addr == i_rd_addr_b) ? i_wr_data : r_bank[i_rd_addr_b];
endmodule

// File: rtl/id_stage_hz.sv
// id_stage_hz: instruction decode stage with register bank, branch/jump
// resolution, load-use hazard detection and a registered ID/EX output.
//   in : i_clock, i_reset, i_enable, i_inst, i_pc (PC+4), WB port,
//        EX load info (i_ex_mem_read, i_ex_rt)
//   out: fetch control (o_pc_write, o_if_id_write, o_flush_if, o_next_pc,
//        o_stall) and the registered ID/EX bundle (control, operands, regs, pc)
module id_stage_hz
  import id_stage_hz_pkg::*;
#(
  parameter int NB_INST   = 32,
  parameter int NB_PC     = 32,
  parameter int NB_DATA   = 32,
  parameter int NB_REG    = 5,
  parameter int NB_OPCODE = 6,
  parameter int REG_LINK  = REG_LINK_DEF
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [NB_INST-1:0]   i_inst,
  input  logic [NB_PC-1:0]     i_pc,
  input  logic                 i_wb_reg_write,
  input  logic [NB_REG-1:0]    i_wb_reg,
  input  logic [NB_DATA-1:0]   i_wb_data,
  input  logic                 i_ex_mem_read,
  input  logic [NB_REG-1:0]    i_ex_rt,
  output logic                 o_pc_write,
  output logic                 o_if_id_write,
  output logic                 o_flush_if,
  output logic [NB_PC-1:0]     o_next_pc,
  output logic                 o_stall,
  output logic                 o_reg_dest,
  output logic                 o_alu_src,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic                 o_reg_write,
  output logic                 o_halt,
  output logic [NB_OPCODE-1:0] o_alu_op,
  output logic                 o_byte_en,
  output logic                 o_half_en,
  output logic                 o_word_en,
  output logic [NB_DATA-1:0]   o_data_a,
  output logic [NB_DATA-1:0]   o_data_b,
  output logic [NB_DATA-1:0]   o_immediate,
  output logic [NB_DATA-1:0]   o_shamt,
  output logic [NB_REG-1:0]    o_rs,
  output logic [NB_REG-1:0]    o_rt,
  output logic [NB_REG-1:0]    o_rd,
  output logic [NB_PC-1:0]     o_pc
);
  logic [5:0]         w_op, w_fn;
  logic [15:0]        w_imm16;
  logic [25:0]        w_tgt;
  logic [NB_REG-1:0]  w_rs, w_rt, w_rd;
  logic [NB_DATA-1:0] w_data_a, w_data_b, w_imm;

  assign w_op    = i_inst[31:26];
  assign w_fn    = i_inst[5:0];
  assign w_imm16 = i_inst[15:0];
  assign w_tgt   = i_inst[25:0];
  assign w_rs    = NB_REG'(i_inst[25:21]);
  assign w_rt    = NB_REG'(i_inst[20:16]);
  assign w_rd    = NB_REG'(i_inst[15:11]);

  bank_register #(.NB_DATA(NB_DATA), .NB_REG(NB_REG)) u_bank (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_wr_en     (i_wb_reg_write),
    .i_wr_addr   (i_wb_reg),
    .i_wr_data   (i_wb_data),
    .i_rd_addr_a (w_rs),
    .i_rd_addr_b (w_rt),
    .o_rd_data_a (w_data_a),
    .o_rd_data_b (w_data_b)
  );

  // ---------------- decode ----------------
  ctrl_t                w_ctrl;
  logic [NB_OPCODE-1:0] w_alu_op;
  logic w_is_halt, w_rd_rt, w_zext, w_lui, w_br, w_jmp, w_jreg, w_jal;

  always_comb begin
    w_ctrl    = CTRL_NOP;
    w_alu_op  = '0;
    w_is_halt = 1'b0;
    w_rd_rt   = 1'b0;
    w_zext    = 1'b0;
    w_lui     = 1'b0;
    w_br      = 1'b0;
    w_jmp     = 1'b0;
    w_jreg    = 1'b0;
    w_jal     = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_rd_rt = 1'b1;
        case (w_fn)
          FN_ADD, FN_ADDU, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLL, FN_SRL, FN_SRA, FN_JALR: begin
            w_ctrl.reg_dest  = 1'b1;
            w_ctrl.reg_write = 1'b1;
            w_alu_op         = NB_OPCODE'(w_fn);
            w_jreg           = (w_fn == FN_JALR);
          end
          FN_JR: begin
            w_alu_op = NB_OPCODE'(w_fn);
            w_jreg   = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_alu_op         = NB_OPCODE'(w_op);
        w_zext           = (w_op == OP_ANDI) || (w_op == OP_ORI) || (w_op == OP_XORI);
        w_lui            = (w_op == OP_LUI);
      end
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.byte_en   = (w_op == OP_LB) || (w_op == OP_LBU);
        w_ctrl.half_en   = (w_op == OP_LH) || (w_op == OP_LHU);
        w_ctrl.word_en   = (w_op == OP_LW);
        w_alu_op         = NB_OPCODE'(w_op);
      end
      OP_SB, OP_SH, OP_SW: begin
        w_rd_rt          = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.mem_write = 1'b1;
        w_ctrl.byte_en   = (w_op == OP_SB);
        w_ctrl.half_en   = (w_op == OP_SH);
        w_ctrl.word_en   = (w_op == OP_SW);
        w_alu_op         = NB_OPCODE'(w_op);
      end
      OP_BEQ, OP_BNE: begin
        w_rd_rt  = 1'b1;
        w_br     = 1'b1;
        w_alu_op = NB_OPCODE'(w_op);
      end
      OP_J, OP_JAL: begin
        w_jmp            = 1'b1;
        w_jal            = (w_op == OP_JAL);
        w_ctrl.reg_write = (w_op == OP_JAL);
        w_alu_op         = NB_OPCODE'(w_op);
      end
      OP_HALT: begin
        w_is_halt = 1'b1;
        w_alu_op  = NB_OPCODE'(w_op);
      end
      default: ;
    endcase
  end

  always_comb begin
    if (w_lui)       w_imm = NB_DATA'({w_imm16, 16'h0000});
    else if (w_zext) w_imm = NB_DATA'(w_imm16);
    else             w_imm = {{(NB_DATA-16){w_imm16[15]}}, w_imm16};
  end

  // ---------------- hazards / control flow ----------------
  logic r_halt;
  logic w_stall, w_br_take, w_taken, w_bubble;

  assign w_stall = i_ex_mem_read && (i_ex_rt != '0) &&
                   ((i_ex_rt == w_rs) || (w_rd_rt && (i_ex_rt == w_rt)));

  // BEQ takes on equal, BNE on not-equal
  assign w_br_take = w_br && ((w_data_a == w_data_b) == (w_op == OP_BEQ));
  // a stalled branch is left for the retry next cycle
  assign w_taken   = !w_stall && (w_br_take || w_jmp || w_jreg);

  always_comb begin
    if (w_jreg)     o_next_pc = NB_PC'(w_data_a);
    else if (w_jmp) o_next_pc = {i_pc[NB_PC-1:28], w_tgt, 2'b00};
    else if (w_br)  o_next_pc = i_pc + {{(NB_PC-18){w_imm16[15]}}, w_imm16, 2'b00};
    else            o_next_pc = i_pc;
  end

  assign o_stall       = w_stall;
  assign o_flush_if    = w_taken;
  assign o_pc_write    = !w_stall && !r_halt;
  assign o_if_id_write = !w_stall && !r_halt;

  // ---------------- ID/EX register ----------------
  ctrl_t                r_ctrl;
  logic [NB_OPCODE-1:0] r_alu_op;
  logic [NB_DATA-1:0]   r_data_a, r_data_b, r_imm, r_shamt;
  logic [NB_REG-1:0]    r_rs, r_rt, r_rd;
  logic [NB_PC-1:0]     r_pc;

  assign w_bubble = w_stall || r_halt;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_ctrl   <= CTRL_NOP;
      r_alu_op <= '0;
      r_data_a <= '0;
      r_data_b <= '0;
      r_imm    <= '0;
      r_shamt  <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_rd     <= '0;
      r_pc     <= '0;
      r_halt   <= 1'b0;
    end else if (i_enable) begin
      if (w_bubble) begin
        r_ctrl   <= CTRL_NOP;
        r_alu_op <= '0;
        r_data_a <= '0;
        r_data_b <= '0;
        r_imm    <= '0;
        r_shamt  <= '0;
        r_rs     <= '0;
        r_rt     <= '0;
        r_rd     <= '0;
        r_pc     <= '0;
      end else begin
        r_ctrl   <= w_ctrl;
        r_alu_op <= w_alu_op;
        r_data_a <= w_data_a;
        r_data_b <= w_data_b;
        r_imm    <= w_imm;
        r_shamt  <= NB_DATA'(i_inst[10:6]);
        r_rs     <= w_rs;
        r_rt     <= w_rt;
        r_rd     <= w_jal ? NB_REG'(REG_LINK) : w_rd;
        r_pc     <= i_pc;
        if (w_is_halt) r_halt <= 1'b1;
      end
    end
  end

  assign o_reg_dest  = r_ctrl.reg_dest;
  assign o_alu_src   = r_ctrl.alu_src;
  assign o_mem_read  = r_ctrl.mem_read;
  assign o_mem_write = r_ctrl.mem_write;
  assign o_reg_write = r_ctrl.reg_write;
  assign o_byte_en   = r_ctrl.byte_en;
  assign o_half_en   = r_ctrl.half_en;
  assign o_word_en   = r_ctrl.word_en;
  assign o_halt      = r_halt;
  assign o_alu_op    = r_alu_op;
  assign o_data_a    = r_data_a;
  assign o_data_b    = r_data_b;
  assign o_immediate = r_imm;
  assign o_shamt     = r_shamt;
  assign o_rs        = r_rs;
  assign o_rt        = r_rt;
  assign o_rd        = r_rd;
  assign o_pc        = r_pc;
endmodule

// File: tb/tb_id_stage_hz.sv
module tb_id_stage_hz;
  logic        i_clock = 1'b0;
  logic        i_reset, i_enable;
  logic [31:0] i_inst, i_pc, i_wb_data;
  logic        i_wb_reg_write, i_ex_mem_read;
  logic [4:0]  i_wb_reg, i_ex_rt;
  logic        o_pc_write, o_if_id_write, o_flush_if, o_stall;
  logic [31:0] o_next_pc;
  logic        o_reg_dest, o_alu_src, o_mem_read, o_mem_write, o_reg_write, o_halt;
  logic [5:0]  o_alu_op;
  logic        o_byte_en, o_half_en, o_word_en;
  logic [31:0] o_data_a, o_data_b, o_immediate, o_shamt, o_pc;
  logic [4:0]  o_rs, o_rt, o_rd;

  id_stage_hz dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_inst(i_inst), .i_pc(i_pc),
    .i_wb_reg_write(i_wb_reg_write), .i_wb_reg(i_wb_reg), .i_wb_data(i_wb_data),
    .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt),
    .o_pc_write(o_pc_write), .o_if_id_write(o_if_id_write), .o_flush_if(o_flush_if),
    .o_next_pc(o_next_pc), .o_stall(o_stall), .o_reg_dest(o_reg_dest), .o_alu_src(o_alu_src),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_reg_write(o_reg_write),
    .o_halt(o_halt), .o_alu_op(o_alu_op), .o_byte_en(o_byte_en), .o_half_en(o_half_en),
    .o_word_en(o_word_en), .o_data_a(o_data_a), .o_data_b(o_data_b),
    .o_immediate(o_immediate), .o_shamt(o_shamt), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
    .o_pc(o_pc)
  );

  always #5 i_clock = ~i_clock;

  int total = 0;
  int bad   = 0;

  // instruction kinds used by the reference model
  localparam int K_SRA = 10, K_JR = 11, K_JALR = 12, K_ADDI = 13, K_ANDI = 15, K_XORI = 17,
                 K_LUI = 18, K_LB = 19, K_LBU = 20, K_LH = 21, K_LHU = 22, K_LW = 23,
                 K_SB = 24, K_SH = 25, K_SW = 26, K_BEQ = 27, K_BNE = 28, K_J = 29,
                 K_JAL = 30, K_BAD = 31;
  localparam logic [5:0] CODE [32] = '{
    6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h08, 6'h09,
    6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
    6'h20, 6'h24, 6'h21, 6'h25, 6'h23, 6'h28, 6'h29, 6'h2B,
    6'h04, 6'h05, 6'h02, 6'h03, 6'h00};
  localparam logic [5:0] BADOP [4] = '{6'h01, 6'h10, 6'h1C, 6'h3E};

  typedef struct packed {
    logic reg_dest, alu_src, mem_read, mem_write, reg_write, byte_en, half_en, word_en;
    logic [5:0]  alu_op;
    logic [31:0] a, b, imm, shamt;
    logic [4:0]  rs, rt, rd;
    logic [31:0] pc;
  } exp_t;

  logic [31:0] mreg [32];

  function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [4:0] sh, logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // expected ID/EX contents for an instruction of kind k that is not stalled
  function automatic exp_t model(int k, logic [31:0] inst, logic [31:0] pc,
                                 logic [31:0] a, logic [31:0] b);
    exp_t e;
    e = '0;
    e.a = a; e.b = b; e.pc = pc;
    e.imm   = {{16{inst[15]}}, inst[15:0]};
    e.shamt = {27'b0, inst[10:6]};
    e.rs = inst[25:21]; e.rt = inst[20:16]; e.rd = inst[15:11];
    if (k <= K_JALR) e.alu_op = inst[5:0];
    else if (k != K_BAD) e.alu_op = inst[31:26];
    if (k <= K_SRA || k == K_JALR) begin e.reg_dest = 1; e.reg_write = 1; end
    if (k >= K_ADDI && k <= K_LW) begin e.alu_src = 1; e.reg_write = 1; end
    if (k >= K_ANDI && k <= K_XORI) e.imm = {16'b0, inst[15:0]};
    if (k == K_LUI) e.imm = {inst[15:0], 16'b0};
    if (k >= K_LB && k <= K_LW) e.mem_read = 1;
    if (k >= K_SB && k <= K_SW) begin e.alu_src = 1; e.mem_write = 1; end
    e.byte_en = (k == K_LB || k == K_LBU || k == K_SB);
    e.half_en = (k == K_LH || k == K_LHU || k == K_SH);
    e.word_en = (k == K_LW || k == K_SW);
    if (k == K_JAL) begin e.reg_write = 1; e.rd = 5'd31; end
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idex(exp_t e, bit bub);
    chk("reg_dest", o_reg_dest, e.reg_dest);   chk("alu_src", o_alu_src, e.alu_src);
    chk("mem_read", o_mem_read, e.mem_read);   chk("mem_write", o_mem_write, e.mem_write);
    chk("reg_write", o_reg_write, e.reg_write); chk("alu_op", o_alu_op, e.alu_op);
    chk("byte_en", o_byte_en, e.byte_en);      chk("half_en", o_half_en, e.half_en);
    chk("word_en", o_word_en, e.word_en);      chk("data_a", o_data_a, e.a);
    chk("data_b", o_data_b, e.b);              chk("imm", o_immediate, e.imm);
    chk("shamt", o_shamt, e.shamt);            chk("halt", o_halt, 0);
    if (!bub) begin
      chk("rs", o_rs, e.rs); chk("rt", o_rt, e.rt); chk("rd", o_rd, e.rd); chk("pc", o_pc, e.pc);
    end
  endtask

  task automatic drv(logic [31:0] inst, logic [31:0] pc, logic we, logic [4:0] wr,
                     logic [31:0] wd, logic exr, logic [4:0] ext);
    i_enable = 1'b1; i_inst = inst; i_pc = pc;
    i_wb_reg_write = we; i_wb_reg = wr; i_wb_data = wd;
    i_ex_mem_read = exr; i_ex_rt = ext;
  endtask

  task automatic tick();
    @(posedge i_clock); #1;
  endtask

  logic [31:0] add_16_17_18, inst, pc, wd, a, b, tpc;
  logic [4:0]  rs, rt, rd, wr, ext;
  logic        we, exr, en, stl, tk, pbub;
  int          k;
  exp_t        e, pe;

  initial begin
    add_16_17_18 = rtype(5'd16, 5'd17, 5'd18, 5'd0, 6'h20);
    add_16_17_18 = rtype(5'd17, 5'd18, 5'd16, 5'd0, 6'h20); // add $16,$17,$18
    i_reset = 1'b1;
    drv(32'h0, 32'h0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_reg_write", o_reg_write, 0); chk("rst_alu_op", o_alu_op, 0);
    chk("rst_data_a", o_data_a, 0);       chk("rst_rd", o_rd, 0);
    chk("rst_pc", o_pc, 0);               chk("rst_halt", o_halt, 0);
    i_reset = 1'b0;

    // fill regs 16..18
    for (int r = 16; r <= 18; r++) begin
      drv(32'h0, 32'h0, 1, 5'(r), 32'(r), 0, 0); tick();
    end

    drv(add_16_17_18, 32'h40, 0, 0, 0, 0, 0); #1;
    chk("add_stall", o_stall, 0); chk("add_pc_write", o_pc_write, 1);
    tick();
    chk("add_data_a", o_data_a, 17); chk("add_data_b", o_data_b, 18);
    chk("add_rd", o_rd, 16);         chk("add_reg_write", o_reg_write, 1);
    chk("add_alu_op", o_alu_op, 6'b100000);

    // write-through bypass, and reg 0 stays 0
    drv(rtype(5'd17, 5'd0, 5'd1, 5'd0, 6'h20), 32'h0, 1, 5'd17, 32'd99, 0, 0); tick();
    chk("bypass_a", o_data_a, 99);
    drv(rtype(5'd0, 5'd0, 5'd1, 5'd0, 6'h20), 32'h0, 1, 5'd0, 32'd55, 0, 0); tick();
    chk("r0_bypass", o_data_a, 0);
    drv(rtype(5'd0, 5'd0, 5'd1, 5'd0, 6'h20), 32'h0, 0, 0, 0, 0, 0); tick();
    chk("r0_stored", o_data_a, 0);

    // load-use
    drv(add_16_17_18, 32'h0, 0, 0, 0, 1, 5'd17); #1;
    chk("lu_stall", o_stall, 1); chk("lu_pc_write", o_pc_write, 0);
    chk("lu_if_id_write", o_if_id_write, 0); chk("lu_flush", o_flush_if, 0);
    tick();
    chk("lu_reg_write", o_reg_write, 0); chk("lu_reg_dest", o_reg_dest, 0);
    chk("lu_alu_op", o_alu_op, 0);       chk("lu_data_a", o_data_a, 0);
    drv(add_16_17_18, 32'h0, 0, 0, 0, 1, 5'd18); #1; chk("lu_rt_stall", o_stall, 1);
    drv(itype(6'h08, 5'd16, 5'd17, 16'h1), 32'h0, 0, 0, 0, 1, 5'd17); #1;
    chk("lu_addi_rt_nostall", o_stall, 0);
    drv(add_16_17_18, 32'h0, 0, 0, 0, 1, 5'd0); #1; chk("lu_r0_nostall", o_stall, 0);
    tick(); chk("lu_r0_reg_write", o_reg_write, 1);

    // branches: reg17 bypassed to 16 -> equal
    drv(itype(6'h04, 5'd16, 5'd17, 16'h00FF), 32'h100, 1, 5'd17, 32'd16, 0, 0); #1;
    chk("beq_flush", o_flush_if, 1); chk("beq_next_pc", o_next_pc, 32'h4FC);
    tick();
    drv(itype(6'h04, 5'd16, 5'd17, 16'h00FF), 32'h100, 1, 5'd17, 32'd17, 0, 0); #1;
    chk("beq_ne_flush", o_flush_if, 0);
    tick();
    drv(itype(6'h04, 5'd16, 5'd16, 16'h00FF), 32'h100, 0, 0, 0, 1, 5'd16); #1;
    chk("beq_stall_flush", o_flush_if, 0); chk("beq_stall", o_stall, 1);
    tick();

    // jal / jr
    drv({6'h03, 26'h00000FF}, 32'h100, 0, 0, 0, 0, 0); #1;
    chk("jal_flush", o_flush_if, 1); chk("jal_next_pc", o_next_pc, 32'h3FC);
    tick();
    chk("jal_rd", o_rd, 31); chk("jal_pc", o_pc, 32'h100); chk("jal_reg_write", o_reg_write, 1);
    drv(rtype(5'd16, 5'd0, 5'd0, 5'd0, 6'h08), 32'h200, 0, 0, 0, 0, 0); #1;
    chk("jr_flush", o_flush_if, 1); chk("jr_next_pc", o_next_pc, 16);
    tick();
    drv(add_16_17_18, 32'h44, 0, 0, 0, 0, 0); i_enable = 1'b0; tick();
    chk("hold_pc", o_pc, 32'h200); chk("hold_reg_write", o_reg_write, 0);

    // randomized section against the behavioural model
    for (int r = 0; r < 32; r++) mreg[r] = 32'h0;
    mreg[16] = 16; mreg[17] = 17; mreg[18] = 18;
    pe = '0; pbub = 1'b1;
    for (int n = 0; n < 400; n++) begin
      k  = $urandom_range(0, 31);
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
      if (k <= K_JALR) inst = rtype(rs, rt, rd, 5'($urandom), CODE[k]);
      else if (k == K_J || k == K_JAL) inst = {CODE[k], 26'($urandom)};
      else if (k == K_BAD) inst = itype(BADOP[$urandom_range(0, 3)], rs, rt, 16'($urandom));
      else inst = itype(CODE[k], rs, rt, 16'($urandom));
      pc  = $urandom & 32'hFFFF_FFFC;
      we  = 1'($urandom); wr = 5'($urandom_range(0, 7)); wd = 32'($urandom_range(0, 3));
      exr = ($urandom_range(0, 3) == 0); ext = 5'($urandom_range(0, 7));
      en  = (n == 0) || ($urandom_range(0, 7) != 0);
      drv(inst, pc, we, wr, wd, exr, ext); i_enable = en;
      a = (inst[25:21] == 0) ? 0 : (we && wr == inst[25:21]) ? wd : mreg[inst[25:21]];
      b = (inst[20:16] == 0) ? 0 : (we && wr == inst[20:16]) ? wd : mreg[inst[20:16]];
      stl = exr && ext != 0 && (ext == inst[25:21] ||
            ((k <= K_JALR || (k >= K_SB && k <= K_BNE)) && ext == inst[20:16]));
      tk  = 0; tpc = 0;
      if ((k == K_BEQ && a == b) || (k == K_BNE && a != b)) begin
        tk = 1; tpc = pc + {{14{inst[15]}}, inst[15:0], 2'b00};
      end
      if (k == K_J || k == K_JAL) begin tk = 1; tpc = {pc[31:28], inst[25:0], 2'b00}; end
      if (k == K_JR || k == K_JALR) begin tk = 1; tpc = a; end
      tk = tk && !stl;
      #1;
      chk("r_stall", o_stall, stl); chk("r_pc_write", o_pc_write, !stl);
      chk("r_if_id_write", o_if_id_write, !stl); chk("r_flush", o_flush_if, tk);
      if (tk) chk("r_next_pc", o_next_pc, tpc);
      if (en) begin
        e = stl ? exp_t'('0) : model(k, inst, pc, a, b);
        pe = e; pbub = stl;
      end
      tick();
      if (we && wr != 0) mreg[wr] = wd;
      chk_idex(pe, pbub);
    end

    // halt is sticky and turns later captures into bubbles
    drv({6'h3F, 26'h0}, 32'h0, 0, 0, 0, 0, 0); tick();
    chk("halt_set", o_halt, 1); chk("halt_pc_write", o_pc_write, 0);
    chk("halt_if_id_write", o_if_id_write, 0);
    drv(add_16_17_18, 32'h0, 0, 0, 0, 0, 0); tick();
    chk("halt_sticky", o_halt, 1); chk("halt_bubble_rw", o_reg_write, 0);
    chk("halt_bubble_op", o_alu_op, 0); chk("halt_pc_write2", o_pc_write, 0);

    // async reset mid-stall, between clock edges
    drv(add_16_17_18, 32'h0, 0, 0, 0, 1, 5'd17); #1;
    chk("pre_rst_stall", o_stall, 1);
    #1 i_reset = 1'b1; #1;
    chk("arst_halt", o_halt, 0); chk("arst_reg_write", o_reg_write, 0);
    chk("arst_alu_op", o_alu_op, 0); chk("arst_pc", o_pc, 0);
    drv(add_16_17_18, 32'h0, 0, 0, 0, 0, 0); #1;
    chk("arst_pc_write", o_pc_write, 1);
    i_reset = 1'b0;
    tick();
    chk("arst_bank_a", o_data_a, 0); chk("arst_bank_b", o_data_b, 0);
    chk("arst_post_rw", o_reg_write, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_stage_hz.md
Name: id_stage_hz

Overview:
Parametrised successor of the DECODE stage. It combines the register bank with write-through bypass, instruction decode/control generation, branch and jump resolution in ID, and load-use hazard detection. It also provides a registered ID/EX output with stall, bubble and sticky halt. It sits between the IF/ID latch and EX and drives PC-write, IF/ID-write and IF-flush back to fetch.

Parameters:
NB_INST, 32, instruction width
NB_PC, 32, PC width
NB_DATA, 32, register/data width
NB_REG, 5, register address width (bank depth 2**NB_REG)
NB_OPCODE, 6, opcode/funct width
REG_LINK, 31, link register index for JAL

Ports:
i_clock  in  1  clock, posedge
i_reset  in  1  async, active-high
i_enable  in  1  pipeline advance; 0 holds all registered state
i_inst  in  NB_INST  instruction from IF/ID
i_pc  in  NB_PC  PC+4 of i_inst
i_wb_reg_write  in  1  WB write strobe
i_wb_reg  in  NB_REG  WB destination
i_wb_data  in  NB_DATA  WB data
i_ex_mem_read  in  1  instruction in EX is a load
i_ex_rt  in  NB_REG  load destination in EX
o_pc_write, o_if_id_write  out  1 each  0 during stall or halt
o_flush_if  out  1  comb; taken branch/jump
o_next_pc  out  NB_PC  comb; branch/jump target
o_stall  out  1  comb; load-use detected
o_reg_dest, o_alu_src, o_mem_read, o_mem_write, o_reg_write, o_halt  out  1 each  registered control
o_alu_op  out  NB_OPCODE  registered; funct for R-type, opcode otherwise
o_byte_en, o_half_en, o_word_en  out  1 each  registered memory width
o_data_a, o_data_b, o_immediate, o_shamt  out  NB_DATA each  registered operands (shamt zero-extended)
o_rs, o_rt, o_rd  out  NB_REG each  registered; o_rd = REG_LINK for JAL
o_pc  out  NB_PC  registered link value (= i_pc)

Behaviour:
- Reset is async, active-high. All registered outputs go to 0, and all bank entries go to 0. Halt is cleared.
- Register bank: posedge write when i_wb_reg_write and i_wb_reg != 0. Register 0 always reads 0. Reads are combinational, with write-through: same-cycle write to the read address returns i_wb_data.
- Fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0].
- Immediate: sign-extended, except ANDI/ORI/XORI, which are zero-extended. LUI gives imm<<16.
- Supported: R-type (ADD/ADDU/SUB/AND/OR/XOR/NOR/SLT/SLL/SRL/SRA/JR/JALR), ADDI, ANDI, ORI, XORI, SLTI, LUI, LB/LH/LW/LBU/LHU, SB/SH/SW, BEQ, BNE, J, JAL, HALT (opcode all-ones).
- Any other opcode decodes as a NOP bubble: all control 0.
- Load-use: o_stall=1 when i_ex_mem_read and i_ex_rt != 0 and i_ex_rt equals rs, or equals rt for instructions that read rt (R-type, store, branch).
- During a stall: o_pc_write=0, o_if_id_write=0, o_flush_if=0, and the ID/EX register loads a bubble (control 0, operands don't-care but driven 0).
- Branch/jump resolution, evaluated only when not stalled:
  - BEQ/BNE compares bypassed data_a/data_b. If taken, o_next_pc = i_pc + (imm<<2).
  - J/JAL: o_next_pc = {i_pc[NB_PC-1:28], target, 2'b00}.
  - JR/JALR: o_next_pc = data_a.
  - When taken: o_flush_if=1. No delay slot.
- Link: JAL and JALR set reg_write=1, and o_pc carries i_pc as the value to write.
- ID/EX register, on posedge when i_enable=1:
  - stall -> bubble;
  - else capture decode.
  - When i_enable=0, hold all state (bank writes still occur).
- Latency: 1 cycle from i_inst to registered outputs. o_stall, o_flush_if and o_next_pc are same-cycle combinational.
- Halt: HALT captured once sets o_halt=1 sticky until reset. While halted, o_pc_write=0, o_if_id_write=0, and all later captures are bubbles with o_halt held at 1.
- Simultaneous stall and branch: stall wins, and the branch is re-evaluated next cycle.
- Reset asserted mid-stall clears everything immediately.

Decomposition:
- Shared package: opcode/funct localparams, control-bundle field order, HALT and NOP encodings, and REG_LINK.
- One sub-module, bank_register: the parametrised register bank with write-through read ports.

Test Plan:
- Reset, then write 16/17/18 to regs 16/17/18. Decode add $16,$17,$18 -> next cycle o_data_a=17, o_data_b=18, o_rd=16, o_reg_write=1, o_alu_op=6'b100000.
- Same-cycle WB to reg 17 with 99 while decoding a read of $17 -> o_data_a=99 (bypass). A write to reg 0 is ignored: reads 0.
- i_ex_mem_read=1, i_ex_rt=17, decode add using $17 -> o_stall=1, o_pc_write=0, next-cycle control all 0. With i_ex_rt=0 -> no stall.
- beq $16,$17,255 with equal data, i_pc=0x100 -> o_flush_if=1, o_next_pc=0x4FC. With unequal data -> o_flush_if=0.
- jal 255 with i_pc=0x100 -> o_next_pc=0x3FC, o_rd=31, o_pc=0x100, o_reg_write=1. jr $16 (=16) -> o_next_pc=16.
- HALT, then add -> o_halt=1 sticky, add captured as bubble, o_pc_write=0. Async reset mid-run clears all outputs without waiting for a clock edge.
